// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  // Responder control states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEPTH_DEF   = 64;
  localparam int LATENCY_DEF = 3;

  // Word index comes from addr[7:2].
  localparam int IDX_W = 6;

  // Wait counter must hold LATENCY-2 for LATENCY up to 15.
  localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Word storage: synchronous write, registered read, no reset on contents.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             en,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // One access per enable: store the word, or register it onto the read port.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[idx] <= wdata;
      end else begin
        rdata <= mem[idx];
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency single-outstanding data-memory responder with error checking.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DEPTH_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy
);

  localparam logic [29:0]      DEPTH_W = 30'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_LD  = CNT_W'(LATENCY - 2);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              enter_resp;

  logic              cap_write;
  logic [31:0]       cap_addr;
  logic [31:0]       cap_wdata;

  logic              acc_write;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic              acc_err;

  logic              err_q;
  logic              load_q;
  logic [31:0]       arr_rdata;

  // With LATENCY=1 the storage access happens on the accept edge itself, so
  // the live request is used; otherwise the captured copy is used.
  always_comb begin
    acc_write = cap_write;
    acc_addr  = cap_addr;
    acc_wdata = cap_wdata;
    if (state == IDLE) begin
      acc_write = req_write;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
    end
    acc_err = (acc_addr[1:0] != 2'b00) || (acc_addr[31:2] >= DEPTH_W);
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic; enter_resp marks the edge on which storage is accessed.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    enter_resp = 1'b0;
    req_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (LATENCY == 1) begin
            state_nxt  = RESP;
            enter_resp = 1'b1;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_LD;
          end
        end
      end
      WAIT: begin
        if (cnt == '0) begin
          state_nxt  = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Capture the request on accept so later req_* activity is ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_write <= 1'b0;
      cap_addr  <= '0;
      cap_wdata <= '0;
    end else if (req_valid && req_ready) begin
      cap_write <= req_write;
      cap_addr  <= req_addr;
      cap_wdata <= req_wdata;
    end
  end

  // Response flags, fixed on entry to RESP and cleared on the handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end else if (enter_resp) begin
      err_q  <= acc_err;
      load_q <= !acc_write && !acc_err;
    end else if (state == RESP && resp_ready) begin
      err_q  <= 1'b0;
      load_q <= 1'b0;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .en    (enter_resp && !acc_err),
    .we    (acc_write),
    .idx   (acc_addr[7:2]),
    .wdata (acc_wdata),
    .rdata (arr_rdata)
  );

  assign resp_valid = (state == RESP);
  assign resp_err   = (state == RESP) && err_q;
  assign resp_rdata = (state == RESP && load_q) ? arr_rdata : 32'h0;
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder (LATENCY=3 and LATENCY=1 instances).
module tb_dmem_responder;

  localparam int LAT = 3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, resp_err, busy;
  logic [31:0] resp_rdata;

  logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_resp_ready = 1'b1;
  logic [31:0] b_req_addr = '0, b_req_wdata = '0;
  logic        b_req_ready, b_resp_valid, b_resp_err, b_busy;
  logic [31:0] b_resp_rdata;

  exp_t        sb[$];
  exp_t        sb_b[$];
  logic [31:0] mdl [64];
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(1)) dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
    .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rdata"}, resp_rdata, 32'd0);
    chk({tag, "_err"}, 32'(resp_err), 32'd0);
  endtask

  // One full transaction on the LATENCY=3 instance.
  task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input int hold, input bit early);
    exp_t        e;
    int          edges;
    logic [31:0] v_rd;
    logic        v_err;
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    e.err   = (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    e.rdata = (w || e.err) ? 32'h0 : mdl[a[7:2]];
    if (w && !e.err) mdl[a[7:2]] = d;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid = 1'b0; req_write = ~w; req_addr = a ^ 32'h4; req_wdata = ~d;
    if (early) resp_ready = 1'b1;
    edges = 1;
    while (!resp_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    chk("latency", 32'(edges), 32'(LAT));
    v_rd  = resp_rdata;
    v_err = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_rdata", resp_rdata, v_rd);
      chk("hold_err", 32'(resp_err), 32'(v_err));
      chk("hold_ready", 32'(req_ready), 32'd0);
      chk("hold_busy", 32'(busy), 32'd1);
    end
    e = sb.pop_front();
    chk("rdata", resp_rdata, e.rdata);
    chk("err", 32'(resp_err), 32'(e.err));
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk_idle("post_hs");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_idle("reset");
    chk("b_reset_ready", 32'(b_req_ready), 32'd1);
    chk("b_reset_valid", 32'(b_resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    xact(1'b1, 32'h10, 32'hDEADBEEF, 0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 0, 1'b0);
    xact(1'b1, 32'h13, 32'h1, 0, 1'b0);
    xact(1'b0, 32'h10, 32'h0, 0, 1'b0);
    xact(1'b0, 32'h100, 32'h0, 0, 1'b0);
    xact(1'b1, 32'h20, 32'h11111111, 0, 1'b1);
    xact(1'b0, 32'h10, 32'h0, 5, 1'b0);
    xact(1'b1, 32'h13, 32'h2, 5, 1'b0);

    // Store to 0x20 interrupted by reset while waiting.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h55;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk_idle("mid_rst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xact(1'b0, 32'h20, 32'h0, 0, 1'b0);

    for (int k = 0; k < 4; k++) begin
      logic [31:0] ra, rd;
      ra = {24'h0, 6'($urandom_range(0, 63)), 2'b00};
      rd = $urandom;
      xact(1'b1, ra, rd, 0, 1'b0);
      xact(1'b0, ra, 32'h0, k, 1'b0);
    end

    // LATENCY=1 instance: back-to-back store/load with resp_ready tied high.
    begin
      exp_t e;
      @(negedge clk);
      b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h4; b_req_wdata = 32'hCAFEF00D;
      chk("b_ready_st", 32'(b_req_ready), 32'd1);
      sb_b.push_back('{rdata: 32'h0, err: 1'b0});
      @(posedge clk); #1;
      chk("b_lat_st", 32'(b_resp_valid), 32'd1);
      e = sb_b.pop_front();
      chk("b_rdata_st", b_resp_rdata, e.rdata);
      chk("b_err_st", 32'(b_resp_err), 32'(e.err));
      chk("b_ready_resp", 32'(b_req_ready), 32'd0);
      b_req_write = 1'b0; b_req_wdata = 32'h0;
      sb_b.push_back('{rdata: 32'hCAFEF00D, err: 1'b0});
      @(posedge clk); #1;
      chk("b_gap_valid", 32'(b_resp_valid), 32'd0);
      chk("b_gap_ready", 32'(b_req_ready), 32'd1);
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      chk("b_lat_ld", 32'(b_resp_valid), 32'd1);
      e = sb_b.pop_front();
      chk("b_rdata_ld", b_resp_rdata, e.rdata);
      chk("b_err_ld", 32'(b_resp_err), 32'(e.err));
      @(posedge clk); #1;
      chk("b_done_valid", 32'(b_resp_valid), 32'd0);
      chk("b_done_busy", 32'(b_busy), 32'd0);
    end

    chk("sb_empty", 32'(sb.size() + sb_b.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
